// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Prioritising interrupt controller in front of the processor core.
//   Rising edges on irq_in/nmi_in set pending flags; the lowest-index enabled
//   pending line is requested on INT, the non-maskable source on NMI. The core
//   acknowledges with INA, software retires with eoi. One level of NMI nesting
//   over a maskable handler is supported.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   irq_in[NUM_IRQ]       maskable request lines (rising-edge sensitive)
//   nmi_in                non-maskable request (rising-edge sensitive)
//   mask_we, mask_wdata   mask register write (bit=1 enables a line)
//   eoi                   end-of-interrupt pulse from software
//   INA                   acknowledge from the core
//   INT, NMI              requests to the core
//   INTD                  high while any interrupt is in service
//   irq_id                ID of the acknowledged maskable source
//   pending               pending register (status)
//
// Build option
//   IRQ_SYNC_EN  when defined, irq_in/nmi_in pass through a two-flop
//                synchroniser before edge detection (adds 2 cycles latency).
module interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               eoi,
  input  logic               INA,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [2:0] {IDLE, REQ_INT, REQ_NMI, SVC_INT, SVC_NMI} state_t;

  state_t             state, state_nx;
  logic [NUM_IRQ-1:0] irq_s, irq_prev, mask, irq_set, irq_clr, eligible;
  logic               nmi_s, nmi_prev, nmi_pend, nmi_set, nmi_clr;
  logic               nest, nest_nx;
  logic [ID_W-1:0]    winner, winner_nx, arb_id, irq_id_nx;
  logic               int_nx, nmi_nx, intd_nx, any_eligible;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta;
  logic               nmi_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta <= '0;
      irq_s    <= '0;
      nmi_meta <= 1'b0;
      nmi_s    <= 1'b0;
    end else begin
      irq_meta <= irq_in;
      irq_s    <= irq_meta;
      nmi_meta <= nmi_in;
      nmi_s    <= nmi_meta;
    end
  end
`else
  always_comb begin
    irq_s = irq_in;
    nmi_s = nmi_in;
  end
`endif

  always_comb begin
    irq_set      = irq_s & ~irq_prev;
    nmi_set      = nmi_s & ~nmi_prev;
    eligible     = pending & mask;
    any_eligible = |eligible;
  end

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    arb_id = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (eligible[i-1]) arb_id = ID_W'(i - 1);
    end
  end

  always_comb begin
    state_nx  = state;
    int_nx    = INT;
    nmi_nx    = NMI;
    intd_nx   = INTD;
    irq_id_nx = irq_id;
    winner_nx = winner;
    nest_nx   = nest;
    irq_clr   = '0;
    nmi_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (nmi_pend) begin
          nmi_nx   = 1'b1;
          state_nx = REQ_NMI;
        end else if (any_eligible) begin
          int_nx    = 1'b1;
          winner_nx = arb_id;
          state_nx  = REQ_INT;
        end
      end
      // An acknowledge arriving together with a new NMI is honoured first;
      // the NMI then preempts from SVC_INT as a nested request.
      REQ_INT: begin
        if (INA) begin
          int_nx          = 1'b0;
          irq_id_nx       = winner;
          irq_clr[winner] = 1'b1;
          intd_nx         = 1'b1;
          state_nx        = SVC_INT;
        end else if (nmi_pend) begin
          int_nx   = 1'b0;
          nmi_nx   = 1'b1;
          state_nx = REQ_NMI;
        end
      end
      REQ_NMI: begin
        if (INA) begin
          nmi_nx   = 1'b0;
          nmi_clr  = 1'b1;
          intd_nx  = 1'b1;
          state_nx = SVC_NMI;
        end
      end
      SVC_INT: begin
        if (nmi_pend) begin
          nest_nx  = 1'b1;
          nmi_nx   = 1'b1;
          state_nx = REQ_NMI;
        end else if (eoi) begin
          intd_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      SVC_NMI: begin
        if (eoi) begin
          if (nest) begin
            nest_nx  = 1'b0;
            state_nx = SVC_INT;
          end else begin
            intd_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      INT      <= 1'b0;
      NMI      <= 1'b0;
      INTD     <= 1'b0;
      irq_id   <= '0;
      winner   <= '0;
      nest     <= 1'b0;
      pending  <= '0;
      nmi_pend <= 1'b0;
      mask     <= '0;
      irq_prev <= '0;
      nmi_prev <= 1'b0;
    end else begin
      state    <= state_nx;
      INT      <= int_nx;
      NMI      <= nmi_nx;
      INTD     <= intd_nx;
      irq_id   <= irq_id_nx;
      winner   <= winner_nx;
      nest     <= nest_nx;
      // Set wins over a clear on the same bit.
      pending  <= (pending & ~irq_clr) | irq_set;
      nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_set;
      if (mask_we) mask <= mask_wdata;
      irq_prev <= irq_s;
      nmi_prev <= nmi_s;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model that tracks the
// outstanding request and a stack of interrupts in service.
module tb_interrupt_controller;

  localparam int N    = 8;
  localparam int NONE = -2;
  localparam int RNMI = -1;

  logic         clk, rst_n;
  logic [N-1:0] irq_in, mask_wdata, pending;
  logic         nmi_in, mask_we, eoi, INA, INT, NMI, INTD;
  logic [2:0]   irq_id;

  int checks, failures;

  // reference model state
  logic [N-1:0] m_pend, m_mask, m_prev;
  logic         m_npend, m_nprev;
  logic [2:0]   m_id;
  int           m_req;
  int           stk[$];
`ifdef IRQ_SYNC_EN
  logic [N-1:0] m_s1, m_s2;
  logic         m_n1, m_n2;
`endif

  interrupt_controller #(.NUM_IRQ(N), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .nmi_in(nmi_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .eoi(eoi), .INA(INA),
    .INT(INT), .NMI(NMI), .INTD(INTD), .irq_id(irq_id), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_npend = 1'b0; m_nprev = 1'b0;
    m_id = '0; m_req = NONE; stk.delete();
`ifdef IRQ_SYNC_EN
    m_s1 = '0; m_s2 = '0; m_n1 = 1'b0; m_n2 = 1'b0;
`endif
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic [N-1:0] eff, sets, clr;
    logic         neff, nsets, nclr;
    int           nreq;
`ifdef IRQ_SYNC_EN
    eff = m_s2; m_s2 = m_s1; m_s1 = irq_in;
    neff = m_n2; m_n2 = m_n1; m_n1 = nmi_in;
`else
    eff = irq_in; neff = nmi_in;
`endif
    sets = eff & ~m_prev; nsets = neff & ~m_nprev;
    m_prev = eff; m_nprev = neff;
    clr = '0; nclr = 1'b0; nreq = m_req;
    if (m_req == NONE) begin
      if (stk.size() == 0) begin
        if (m_npend) nreq = RNMI;
        else if ((m_pend & m_mask) != '0) nreq = lowest(m_pend & m_mask);
      end else if (stk[$] >= 0) begin
        if (m_npend) nreq = RNMI;
        else if (eoi) void'(stk.pop_back());
      end else if (eoi) begin
        void'(stk.pop_back());
      end
    end else if (m_req == RNMI) begin
      if (INA) begin stk.push_back(RNMI); nclr = 1'b1; nreq = NONE; end
    end else begin
      if (INA) begin
        m_id = 3'(m_req); clr[m_req] = 1'b1; stk.push_back(m_req); nreq = NONE;
      end else if (m_npend) begin
        nreq = RNMI;
      end
    end
    m_req   = nreq;
    m_pend  = (m_pend & ~clr) | sets;
    m_npend = (m_npend & ~nclr) | nsets;
    if (mask_we) m_mask = mask_wdata;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("int",     32'(INT),     32'(m_req >= 0));
    check("nmi",     32'(NMI),     32'(m_req == RNMI));
    check("intd",    32'(INTD),    32'(stk.size() != 0));
    check("irq_id",  32'(irq_id),  32'(m_id));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq_in = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    eoi = 1'b0; INA = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_int",     32'(INT),     32'd0);
    check("rst_nmi",     32'(NMI),     32'd0);
    check("rst_intd",    32'(INTD),    32'd0);
    check("rst_irq_id",  32'(irq_id),  32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_wdata = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic rand_inputs();
    irq_in ^= N'($urandom & $urandom & $urandom);
    if ($urandom_range(0, 19) == 0) nmi_in = ~nmi_in;
    mask_we    = ($urandom_range(0, 15) == 0);
    mask_wdata = N'($urandom);
    INA        = ($urandom_range(0, 2) == 0);
    eoi        = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    checks = 0; failures = 0;

    // basic handshake
    do_reset();
    write_mask(8'hFF);
    irq_in[5] = 1'b1;
    step(); check("t1_lat1", 32'(INT), 32'd0);
    step(); check("t1_lat2", 32'(INT), 32'd1);
    INA = 1'b1; step(); INA = 1'b0;
    check("t1_ack_int", 32'(INT), 32'd0);
    check("t1_id", 32'(irq_id), 32'd5);
    check("t1_intd", 32'(INTD), 32'd1);
    check("t1_pend5", 32'(pending[5]), 32'd0);
    eoi = 1'b1; step(); eoi = 1'b0;
    check("t1_eoi", 32'(INTD), 32'd0);

    // priority
    do_reset();
    write_mask(8'hFF);
    irq_in = 8'h44;
    step(); step(); check("t2_int", 32'(INT), 32'd1);
    INA = 1'b1; step(); INA = 1'b0;
    check("t2_id_first", 32'(irq_id), 32'd2);
    eoi = 1'b1; step(); eoi = 1'b0;
    step(); check("t2_rearb", 32'(INT), 32'd1);
    INA = 1'b1; step(); INA = 1'b0;
    check("t2_id_second", 32'(irq_id), 32'd6);

    // masking
    do_reset();
    irq_in[1] = 1'b1;
    step(); check("t3_pend", 32'(pending), 32'h02);
    step(); check("t3_masked", 32'(INT), 32'd0);
    write_mask(8'h02);
    check("t3_wr_edge", 32'(INT), 32'd0);
    step(); check("t3_enabled", 32'(INT), 32'd1);

    // NMI preemption of a maskable handler
    do_reset();
    write_mask(8'hFF);
    irq_in[3] = 1'b1;
    step(); step();
    INA = 1'b1; step(); INA = 1'b0;
    check("t4_id", 32'(irq_id), 32'd3);
    nmi_in = 1'b1;
    step(); step();
    check("t4_nmi", 32'(NMI), 32'd1);
    check("t4_intd_req", 32'(INTD), 32'd1);
    INA = 1'b1; step(); INA = 1'b0;
    check("t4_nmi_ack", 32'(NMI), 32'd0);
    eoi = 1'b1; step(); eoi = 1'b0;
    check("t4_nest_intd", 32'(INTD), 32'd1);
    check("t4_nest_id", 32'(irq_id), 32'd3);
    check("t4_nest_int", 32'(INT), 32'd0);
    eoi = 1'b1; step(); eoi = 1'b0;
    check("t4_done", 32'(INTD), 32'd0);

    // set and clear of the same pending bit in one cycle
    do_reset();
    write_mask(8'hFF);
    irq_in[4] = 1'b1; step();
    irq_in[4] = 1'b0; step();
    check("t5_int", 32'(INT), 32'd1);
    irq_in[4] = 1'b1; INA = 1'b1; step(); INA = 1'b0;
    check("t5_pend4", 32'(pending[4]), 32'd1);
    check("t5_id", 32'(irq_id), 32'd4);

    // asynchronous reset mid-handshake
    do_reset();
    write_mask(8'hFF);
    irq_in[0] = 1'b1;
    step(); step();
    check("t6_int", 32'(INT), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_int0", 32'(INT), 32'd0);
    check("t6_nmi0", 32'(NMI), 32'd0);
    check("t6_intd0", 32'(INTD), 32'd0);
    check("t6_pend0", 32'(pending), 32'd0);
    check("t6_mask0", 32'(dut.mask), 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
